branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer and 2-bit counter table feeding the branch unit. It is looked up with the fetch PC and returns `PcMatchValid`, `JumpTaken`, `CtrlIn` and the predicted target one cycle later, aligned with the IF/ID register. It is written back by the branch unit (`WriteEnable`, `CtrlOut`) with the resolved branch PC and target. It is the storage and lookup side of the branch unit's prediction interface.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/btb_array.sv | 61 ++++++
 rtl/branch_target_buffer.sv | 79 +++++++
 tb/tb_branch_target_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch target buffer.
//   CTR_*       : 2-bit direction counter encodings (stored verbatim).
//   BTB_*       : geometry constants; the entry layout is sized from these,
//                 so the BTB top must be instantiated with matching values.
//   btb_entry_t : one BTB entry (valid, tag, counter, target).
//   btb_index   : PC[IW+1:2] -> entry index.
//   btb_tag     : PC[AW-1:IW+2] -> entry tag.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int BTB_ENTRIES = 16;
  localparam int BTB_AW      = 32;
  localparam int BTB_IW      = $clog2(BTB_ENTRIES);
  localparam int BTB_TW      = BTB_AW - BTB_IW - 2;

  typedef struct packed {
    logic                valid;
    logic [BTB_TW-1:0]   tag;
    logic [1:0]          ctr;
    logic [BTB_AW-1:0]   target;
  } btb_entry_t;

  function automatic logic [BTB_IW-1:0] btb_index(input logic [BTB_AW-1:0] pc);
    return pc[BTB_IW+1:2];
  endfunction

  function automatic logic [BTB_TW-1:0] btb_tag(input logic [BTB_AW-1:0] pc);
    return pc[BTB_AW-1:BTB_IW+2];
  endfunction

endpackage

// File: rtl/btb_array.sv
// btb_array: direct-mapped BTB storage.
//   clk, rst_n     : clock, async active-low reset (clears valid bits only)
//   invalidateAll  : clear every valid bit at the clock edge
//   rdIdx/rdEntry  : combinational read port, write-first bypassed
//   wrEn, wrIdx    : write strobe and entry index
//   wrTag/wrCtr/wrTarget : contents written to entry wrIdx
module btb_array
  import bp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   invalidateAll,
  input  logic [BTB_IW-1:0]      rdIdx,
  output btb_entry_t             rdEntry,
  input  logic                   wrEn,
  input  logic [BTB_IW-1:0]      wrIdx,
  input  logic [BTB_TW-1:0]      wrTag,
  input  logic [1:0]             wrCtr,
  input  logic [BTB_AW-1:0]      wrTarget
);

  logic [BTB_ENTRIES-1:0] validQ;
  logic [BTB_TW-1:0]      tagMem    [BTB_ENTRIES];
  logic [1:0]             ctrMem    [BTB_ENTRIES];
  logic [BTB_AW-1:0]      targetMem [BTB_ENTRIES];

  // Invalidate wins over a same-cycle write: the written entry ends invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
    end else if (invalidateAll) begin
      validQ <= '0;
    end else if (wrEn) begin
      validQ[wrIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIdx]    <= wrTag;
      ctrMem[wrIdx]    <= wrCtr;
      targetMem[wrIdx] <= wrTarget;
    end
  end

  // A bypassed read of a write that invalidateAll is discarding reports
  // invalid; every other read sees pre-invalidation contents.
  always_comb begin
    rdEntry.valid  = validQ[rdIdx];
    rdEntry.tag    = tagMem[rdIdx];
    rdEntry.ctr    = ctrMem[rdIdx];
    rdEntry.target = targetMem[rdIdx];
    if (wrEn && (wrIdx == rdIdx)) begin
      rdEntry.valid  = !invalidateAll;
      rdEntry.tag    = wrTag;
      rdEntry.ctr    = wrCtr;
      rdEntry.target = wrTarget;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB + 2-bit counter lookup for the
// branch unit. Lookup results are registered one cycle after FetchPc.
//   clk, rst_n     : clock, async active-low reset
//   FetchPc        : lookup PC
//   Stall          : hold lookup outputs and LookupCount (writes still happen)
//   InvalidateAll  : clear all valid bits
//   WriteEnable, UpdPc, UpdTarget, CtrlOut : update from the branch unit
//   PcMatchValid, JumpTaken, CtrlIn, PredTarget : registered lookup result
//   HitCount, LookupCount : saturating 16-bit statistics
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int AW      = BTB_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] FetchPc,
  input  logic          Stall,
  input  logic          InvalidateAll,
  input  logic          WriteEnable,
  input  logic [AW-1:0] UpdPc,
  input  logic [AW-1:0] UpdTarget,
  input  logic [1:0]    CtrlOut,
  output logic          PcMatchValid,
  output logic          JumpTaken,
  output logic [1:0]    CtrlIn,
  output logic [AW-1:0] PredTarget,
  output logic [15:0]   HitCount,
  output logic [15:0]   LookupCount
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AW - IW - 2;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  btb_entry_t rdEntry_p0;
  logic       hit_p0;

  btb_array uArray (
    .clk           (clk),
    .rst_n         (rst_n),
    .invalidateAll (InvalidateAll),
    .rdIdx         (btb_index(FetchPc)),
    .rdEntry       (rdEntry_p0),
    .wrEn          (WriteEnable),
    .wrIdx         (btb_index(UpdPc)),
    .wrTag         (btb_tag(UpdPc)),
    .wrCtr         (CtrlOut),
    .wrTarget      (UpdTarget)
  );

  assign hit_p0 = rdEntry_p0.valid && (rdEntry_p0.tag == btb_tag(FetchPc));

  // ---- p0 -> p1: lookup result registers, frozen while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PcMatchValid <= 1'b0;
      JumpTaken    <= 1'b0;
      CtrlIn       <= 2'b00;
      PredTarget   <= '0;
      HitCount     <= '0;
      LookupCount  <= '0;
    end else if (!Stall) begin
      PcMatchValid <= hit_p0;
      JumpTaken    <= hit_p0 && rdEntry_p0.ctr[1];
      CtrlIn       <= hit_p0 ? rdEntry_p0.ctr : CTR_SNT;
      PredTarget   <= hit_p0 ? rdEntry_p0.target : '0;
      LookupCount  <= satInc(LookupCount);
      if (hit_p0) begin
        HitCount <= satInc(HitCount);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] FetchPc;
  logic        Stall, InvalidateAll, WriteEnable;
  logic [31:0] UpdPc, UpdTarget;
  logic [1:0]  CtrlOut;
  logic        PcMatchValid, JumpTaken;
  logic [1:0]  CtrlIn;
  logic [31:0] PredTarget;
  logic [15:0] HitCount, LookupCount;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n), .FetchPc(FetchPc), .Stall(Stall),
    .InvalidateAll(InvalidateAll), .WriteEnable(WriteEnable),
    .UpdPc(UpdPc), .UpdTarget(UpdTarget), .CtrlOut(CtrlOut),
    .PcMatchValid(PcMatchValid), .JumpTaken(JumpTaken), .CtrlIn(CtrlIn),
    .PredTarget(PredTarget), .HitCount(HitCount), .LookupCount(LookupCount)
  );

  int nVec = 0;
  int nBad = 0;

  // Reference model: 16 slots, each remembering the word address (pc>>2)
  // of the branch that last wrote it.
  bit          mValid [16];
  logic [29:0] mWord  [16];
  logic [1:0]  mCtr   [16];
  logic [31:0] mTgt   [16];
  logic        eMatch;
  logic [1:0]  eCtr;
  logic [31:0] eTgt;
  logic [15:0] eLc, eHc;

  typedef struct {
    logic [31:0] fetch;
    logic        stall, inv, we;
    logic [31:0] updPc, updTgt;
    logic [1:0]  ctr;
    logic        xMatch;
    logic [1:0]  xCtr;
    logic [31:0] xTgt;
    logic [15:0] xLc, xHc;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic [31:0] f, logic s, logic i, logic w,
                              logic [31:0] up, logic [31:0] ut, logic [1:0] c,
                              logic xm, logic [1:0] xc, logic [31:0] xt,
                              logic [15:0] xl, logic [15:0] xh);
    vec_t v;
    v.fetch = f; v.stall = s; v.inv = i; v.we = w; v.updPc = up; v.updTgt = ut;
    v.ctr = c; v.xMatch = xm; v.xCtr = xc; v.xTgt = xt; v.xLc = xl; v.xHc = xh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string tag, input logic m, input logic [1:0] c,
                        input logic [31:0] t, input logic [15:0] l, input logic [15:0] h);
    chk({tag, ".PcMatchValid"}, 32'(PcMatchValid), 32'(m));
    chk({tag, ".JumpTaken"},    32'(JumpTaken),    32'(m & c[1]));
    chk({tag, ".CtrlIn"},       32'(CtrlIn),       32'(c));
    chk({tag, ".PredTarget"},   PredTarget,        t);
    chk({tag, ".LookupCount"},  32'(LookupCount),  32'(l));
    chk({tag, ".HitCount"},     32'(HitCount),     32'(h));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mValid[i] = 0;
    eMatch = 0; eCtr = 0; eTgt = 0; eLc = 0; eHc = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, and return 1ns
  // after the edge so outputs are sampled away from it.
  task automatic step(input logic [31:0] f, input logic s, input logic i,
                      input logic w, input logic [31:0] up, input logic [31:0] ut,
                      input logic [1:0] c);
    int fi, ui;
    bit h;
    FetchPc = f; Stall = s; InvalidateAll = i; WriteEnable = w;
    UpdPc = up; UpdTarget = ut; CtrlOut = c;
    @(posedge clk);
    fi = int'((f >> 2) % 16);
    ui = int'((up >> 2) % 16);
    if (!s) begin
      if (w && fi == ui) begin
        h = !i && (up >> 2) == (f >> 2);
        eCtr = h ? c : 2'b00;
        eTgt = h ? ut : 32'h0;
      end else begin
        h = mValid[fi] && mWord[fi] == 30'(f >> 2);
        eCtr = h ? mCtr[fi] : 2'b00;
        eTgt = h ? mTgt[fi] : 32'h0;
      end
      eMatch = h;
      if (eLc != 16'hFFFF) eLc = eLc + 1;
      if (h && eHc != 16'hFFFF) eHc = eHc + 1;
    end
    if (w) begin
      mValid[ui] = 1; mWord[ui] = 30'(up >> 2); mCtr[ui] = c; mTgt[ui] = ut;
    end
    if (i) for (int k = 0; k < 16; k++) mValid[k] = 0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    FetchPc = 0; Stall = 0; InvalidateAll = 0; WriteEnable = 0;
    UpdPc = 0; UpdTarget = 0; CtrlOut = 0;
    modelReset();

    vecs[0]  = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   1, 0);
    vecs[1]  = mk(32'h004, 0,0,1, 32'h100, 32'h240, 2'b10, 0, 2'b00, 32'h0,   2, 0);
    vecs[2]  = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 1, 2'b10, 32'h240, 3, 1);
    vecs[3]  = mk(32'h140, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   4, 1);
    vecs[4]  = mk(32'h008, 0,0,1, 32'h140, 32'h111, 2'b01, 0, 2'b00, 32'h0,   5, 1);
    vecs[5]  = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   6, 1);
    vecs[6]  = mk(32'h140, 0,0,0, 32'h0,   32'h0,   2'b00, 1, 2'b01, 32'h111, 7, 2);
    vecs[7]  = mk(32'h208, 0,0,1, 32'h208, 32'h300, 2'b11, 1, 2'b11, 32'h300, 8, 3);
    vecs[8]  = mk(32'h00C, 0,0,1, 32'h100, 32'h240, 2'b10, 0, 2'b00, 32'h0,   9, 3);
    vecs[9]  = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 1, 2'b10, 32'h240, 10, 4);
    vecs[10] = mk(32'h500, 1,0,1, 32'h100, 32'h240, 2'b00, 1, 2'b10, 32'h240, 10, 4);
    vecs[11] = mk(32'h500, 1,0,1, 32'h100, 32'h240, 2'b00, 1, 2'b10, 32'h240, 10, 4);
    vecs[12] = mk(32'h500, 1,0,1, 32'h100, 32'h240, 2'b00, 1, 2'b10, 32'h240, 10, 4);
    vecs[13] = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 1, 2'b00, 32'h240, 11, 5);
    vecs[14] = mk(32'h208, 0,1,1, 32'h100, 32'h999, 2'b11, 1, 2'b11, 32'h300, 12, 6);
    vecs[15] = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   13, 6);
    vecs[16] = mk(32'h208, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   14, 6);
    vecs[17] = mk(32'h100, 0,1,1, 32'h100, 32'h777, 2'b11, 0, 2'b00, 32'h0,   15, 6);
    vecs[18] = mk(32'h100, 0,0,0, 32'h0,   32'h0,   2'b00, 0, 2'b00, 32'h0,   16, 6);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chkAll("reset", 0, 2'b00, 32'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;   // first edge after release idles with no-stall lookup below
    // That edge was a lookup of FetchPc=0 (miss); account for it in the model.
    eLc = 1;
    chkAll("postrst", 0, 2'b00, 32'h0, 16'h1, 16'h0);
    // Restart counters cleanly for the directed table.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    modelReset();

    // Directed table
    for (int v = 0; v < 19; v++) begin
      step(vecs[v].fetch, vecs[v].stall, vecs[v].inv, vecs[v].we,
           vecs[v].updPc, vecs[v].updTgt, vecs[v].ctr);
      chkAll($sformatf("vec%0d", v), vecs[v].xMatch, vecs[v].xCtr,
             vecs[v].xTgt, vecs[v].xLc, vecs[v].xHc);
    end

    // Randomized traffic on a small PC pool so hits and aliasing are common
    for (int n = 0; n < 400; n++) begin
      logic [31:0] f, up;
      f  = {26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      up = {26'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      step(f, ($urandom_range(0, 9) < 2), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 9) < 4), up, $urandom, 2'($urandom));
      chkAll($sformatf("rnd%0d", n), eMatch, eCtr, eTgt, eLc, eHc);
    end

    // Async reset in the middle of a hit
    step(32'h0, 0, 0, 1, 32'h100, 32'h240, 2'b11);
    step(32'h100, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    chk("prehit.PcMatchValid", 32'(PcMatchValid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chkAll("asyncrst", 0, 2'b00, 32'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    step(32'h100, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    chkAll("afterrst", 0, 2'b00, 32'h0, 16'h1, 16'h0);

    // Saturation of both counters
    step(32'h0, 0, 0, 1, 32'h100, 32'h240, 2'b10);
    for (int n = 0; n < 65540; n++) step(32'h100, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    chkAll("sat", 1, 2'b10, 32'h240, 16'hFFFF, 16'hFFFF);
    step(32'h100, 0, 0, 0, 32'h0, 32'h0, 2'b00);
    chk("sat2.LookupCount", 32'(LookupCount), 32'h0000FFFF);
    chk("sat2.HitCount",    32'(HitCount),    32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
